// File: rtl/instr_dispatch_if.sv
// rtl/instr_dispatch_if.sv - Sequencer-side signal bundle for the instruction dispatch stage
//
// Carries the control-SM handshake (start/abort/ir_load/dr_in), the
// sequencer entry/return codes (IROut/IRIn) and the status outputs.
// Modport slave : the dispatch block (inputs start..IRIn, drives the rest).
// Modport master: the control/sequencer side driving the dispatch block.
interface instr_dispatch_if #(
    parameter int DATA_W = 8,
    parameter int CODE_W = 6,
    parameter int CNT_W  = 16
) ();
    logic              start;
    logic              abort;
    logic              ir_load;
    logic [DATA_W-1:0] dr_in;
    logic [CODE_W-1:0] IRIn;
    logic [CODE_W-1:0] IROut;
    logic [DATA_W-1:0] ir_q;
    logic              running;
    logic              halted;
    logic              illegal_op;
    logic [CNT_W-1:0]  instr_count;

    modport slave (
        input  start, abort, ir_load, dr_in, IRIn,
        output IROut, ir_q, running, halted, illegal_op, instr_count
    );

    modport master (
        output start, abort, ir_load, dr_in, IRIn,
        input  IROut, ir_q, running, halted, illegal_op, instr_count
    );
endinterface

// File: rtl/instr_dispatch.sv
// rtl/instr_dispatch.sv - Instruction register and opcode dispatch ahead of the microcode sequencer
//
// Ports:
//   clk   - system clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - instr_dispatch_if.slave:
//           start/abort     run control from the control SM
//           ir_load/dr_in   load IR from the data register
//           IRIn            sequencer return code (FETCH_CODE = done, HALT_CODE = halt)
//           IROut           entry code presented to the sequencer
//           ir_q            instruction register
//           running/halted  state status
//           illegal_op      sticky illegal-opcode flag
//           instr_count     IR loads since reset (wraps)
module instr_dispatch #(
    parameter int DATA_W     = 8,
    parameter int CODE_W     = 6,
    parameter int CNT_W      = 16,
    parameter int FETCH_CODE = 1,
    parameter int NOP_CODE   = 56,
    parameter int HALT_CODE  = 57
) (
    input  logic           clk,
    input  logic           rst_n,
    instr_dispatch_if.slave bus
);

    localparam logic [CODE_W-1:0] FETCH_C = CODE_W'(FETCH_CODE);
    localparam logic [CODE_W-1:0] NOP_C   = CODE_W'(NOP_CODE);
    localparam logic [CODE_W-1:0] HALT_C  = CODE_W'(HALT_CODE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CODE_W-1:0] iro_q, iro_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ill_q, ill_d;
    logic              running_q, halted_q;
    logic [CODE_W-1:0] opc;

    // Opcodes with a micro-sequence behind them; everything else becomes NOP.
    function automatic logic is_legal(input logic [CODE_W-1:0] code);
        int c;
        c = int'(code);
        return c inside {4, 8, 12, 14, 16, 18, 21, 24, 27, 30, 33, [36:52], 55, 56, 57};
    endfunction

    assign opc = bus.dr_in[CODE_W-1:0];

    always_comb begin
        state_d = state_q;
        iro_d   = iro_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        ill_d   = ill_q;

        case (state_q)
            S_IDLE: begin
                iro_d = '0;
                if (bus.start && !bus.abort) begin
                    state_d = S_FETCH;
                    iro_d   = FETCH_C;
                end
            end
            S_FETCH: begin
                iro_d = FETCH_C;
                if (bus.ir_load) begin
                    ir_d    = bus.dr_in;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_EXEC;
                    // HALT_CODE is in the legal set, so it dispatches unchanged.
                    if (is_legal(opc)) begin
                        iro_d = opc;
                    end else begin
                        iro_d = NOP_C;
                        ill_d = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                // Level check is safe: the sequencer drops IRIn to 0 on its
                // first fetch step, so a stale end code is never re-seen here.
                if (bus.IRIn == HALT_C) begin
                    state_d = S_HALT;
                    iro_d   = HALT_C;
                end else if (bus.IRIn == FETCH_C) begin
                    state_d = S_FETCH;
                    iro_d   = FETCH_C;
                end
            end
            S_HALT: begin
                iro_d = HALT_C;
                if (bus.start) begin
                    state_d = S_FETCH;
                    iro_d   = FETCH_C;
                end
            end
            default: begin
                state_d = S_IDLE;
                iro_d   = '0;
            end
        endcase

        // abort wins over everything else, but keeps IR, count and the flag.
        if (bus.abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            iro_d   = '0;
            ir_d    = ir_q;
            cnt_d   = cnt_q;
            ill_d   = ill_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            iro_q     <= '0;
            ir_q      <= '0;
            cnt_q     <= '0;
            ill_q     <= 1'b0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            iro_q     <= iro_d;
            ir_q      <= ir_d;
            cnt_q     <= cnt_d;
            ill_q     <= ill_d;
            running_q <= (state_d == S_FETCH) || (state_d == S_EXEC);
            halted_q  <= (state_d == S_HALT);
        end
    end

    assign bus.IROut       = iro_q;
    assign bus.ir_q        = ir_q;
    assign bus.running     = running_q;
    assign bus.halted      = halted_q;
    assign bus.illegal_op  = ill_q;
    assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_instr_dispatch.sv
// tb/tb_instr_dispatch.sv - Self-checking bench for instr_dispatch
module tb_instr_dispatch;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_dispatch_if #(.DATA_W(8), .CODE_W(6), .CNT_W(16)) bus ();
    instr_dispatch_if #(.DATA_W(8), .CODE_W(6), .CNT_W(4))  bus_w ();

    instr_dispatch u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    instr_dispatch #(.CNT_W(4)) u_dut_w (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_w.slave)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a mode number plus the code that was dispatched.
    bit legal_tab [64];
    int m_mode = 0;              // 0 idle, 1 fetch, 2 exec, 3 halt
    logic [7:0] m_ir = 8'h00;
    logic [5:0] m_disp = 6'd0;
    bit m_ill = 1'b0;
    int unsigned m_cnt = 0;

    initial begin
        int lst [15] = '{4, 8, 12, 14, 16, 18, 21, 24, 27, 30, 33, 52, 55, 56, 57};
        for (int i = 0; i < 64; i++) legal_tab[i] = 1'b0;
        foreach (lst[i]) legal_tab[lst[i]] = 1'b1;
        for (int i = 36; i <= 51; i++) legal_tab[i] = 1'b1;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode = 0; m_ir = 8'h00; m_disp = 6'd0; m_ill = 1'b0; m_cnt = 0;
        end else if (bus.abort && m_mode != 0) begin
            m_mode = 0;
        end else begin
            case (m_mode)
                0: if (bus.start && !bus.abort) m_mode = 1;
                1: if (bus.ir_load) begin
                    m_ir  = bus.dr_in;
                    m_cnt = (m_cnt + 1) % 65536;
                    if (legal_tab[bus.dr_in % 64]) m_disp = bus.dr_in[5:0];
                    else begin
                        m_disp = 6'd56;
                        m_ill  = 1'b1;
                    end
                    m_mode = 2;
                end
                2: if (bus.IRIn == 6'd57) m_mode = 3;
                   else if (bus.IRIn == 6'd1) m_mode = 1;
                3: if (bus.start) m_mode = 1;
                default: m_mode = 0;
            endcase
        end
    end

    function automatic logic [5:0] exp_iro();
        case (m_mode)
            1: return 6'd1;
            2: return m_disp;
            3: return 6'd57;
            default: return 6'd0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_IROut", bus.IROut, exp_iro());
            chk("m_ir_q", bus.ir_q, m_ir);
            chk("m_running", bus.running, (m_mode == 1 || m_mode == 2));
            chk("m_halted", bus.halted, (m_mode == 3));
            chk("m_illegal", bus.illegal_op, m_ill);
            chk("m_count", bus.instr_count, m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input logic [7:0] d);
        bus.ir_load = 1'b1; bus.dr_in = d;
        tick();
        bus.ir_load = 1'b0;
    endtask

    task automatic ret(input logic [5:0] c);
        bus.IRIn = c;
        tick();
        bus.IRIn = 6'd0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    logic [7:0] vec_dr  [9] = '{8'hC4, 8'h00, 8'h03, 8'h38, 8'h34, 8'h35, 8'h3A, 8'h33, 8'h37};
    logic [5:0] vec_iro [9] = '{6'd4,  6'd56, 6'd56, 6'd56, 6'd52, 6'd56, 6'd56, 6'd51, 6'd55};

    initial begin
        bus.start = 0; bus.abort = 0; bus.ir_load = 0; bus.dr_in = 0; bus.IRIn = 0;
        bus_w.start = 0; bus_w.abort = 0; bus_w.ir_load = 0; bus_w.dr_in = 0; bus_w.IRIn = 0;

        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_IROut", bus.IROut, 0);
        chk("rst_count", bus.instr_count, 0);
        chk("rst_running", bus.running, 0);

        // IDLE ignores ir_load and IRIn
        rst_n = 1'b1;
        bus.ir_load = 1; bus.dr_in = 8'h04; bus.IRIn = 6'd1;
        tick();
        bus.ir_load = 0; bus.IRIn = 0;
        chk("idle_IROut", bus.IROut, 0);
        chk("idle_count", bus.instr_count, 0);

        pulse_start();
        chk("start_IROut", bus.IROut, 1);
        chk("start_running", bus.running, 1);
        chk("start_count", bus.instr_count, 0);

        pulse_start();
        chk("fetch_start_ign", bus.IROut, 1);

        load(8'h04);
        chk("ld04_IROut", bus.IROut, 4);
        chk("ld04_ir_q", bus.ir_q, 8'h04);
        chk("ld04_count", bus.instr_count, 1);
        ret(6'd4);
        chk("exec_stay", bus.IROut, 4);
        ret(6'd1);
        chk("exec_done", bus.IROut, 1);

        load(8'h05);
        chk("ill_IROut", bus.IROut, 56);
        chk("ill_flag", bus.illegal_op, 1);
        ret(6'd1);
        load(8'h24);
        chk("ld24_IROut", bus.IROut, 36);
        chk("ill_sticky", bus.illegal_op, 1);
        chk("ld24_count", bus.instr_count, 3);
        ret(6'd1);

        foreach (vec_dr[i]) begin
            load(vec_dr[i]);
            chk("vec_IROut", bus.IROut, vec_iro[i]);
            ret(6'd1);
        end
        chk("vec_count", bus.instr_count, 12);

        load(8'h39);
        chk("ld57_IROut", bus.IROut, 57);
        chk("ld57_running", bus.running, 1);
        ret(6'd57);
        chk("halt_halted", bus.halted, 1);
        chk("halt_running", bus.running, 0);
        chk("halt_IROut", bus.IROut, 57);
        tick();
        chk("halt_hold", bus.IROut, 57);
        pulse_start();
        chk("resume_IROut", bus.IROut, 1);
        chk("resume_halted", bus.halted, 0);
        chk("resume_count", bus.instr_count, 13);

        load(8'h12);
        chk("ld18_IROut", bus.IROut, 18);
        bus.abort = 1; bus.IRIn = 6'd1; bus.start = 1;
        tick();
        bus.abort = 0; bus.IRIn = 0; bus.start = 0;
        chk("abort_IROut", bus.IROut, 0);
        chk("abort_ir_q", bus.ir_q, 8'h12);
        chk("abort_running", bus.running, 0);
        chk("abort_count", bus.instr_count, 14);

        bus.start = 1; bus.abort = 1;
        tick();
        bus.start = 0; bus.abort = 0;
        chk("idle_start_abort", bus.IROut, 0);

        // abort in FETCH with ir_load pending: load must be dropped
        pulse_start();
        bus.abort = 1; bus.ir_load = 1; bus.dr_in = 8'h08;
        tick();
        bus.abort = 0; bus.ir_load = 0;
        chk("abort_fetch_count", bus.instr_count, 14);
        chk("abort_fetch_ir_q", bus.ir_q, 8'h12);

        // abort from HALT
        pulse_start();
        load(8'h39);
        ret(6'd57);
        bus.abort = 1;
        tick();
        bus.abort = 0;
        chk("abort_halt_halted", bus.halted, 0);
        chk("abort_halt_IROut", bus.IROut, 0);

        // reset mid-EXEC
        pulse_start();
        load(8'h12);
        ret(6'd32);
        chk("pre_rst_IROut", bus.IROut, 18);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_IROut", bus.IROut, 0);
        chk("mid_rst_ir_q", bus.ir_q, 0);
        chk("mid_rst_count", bus.instr_count, 0);
        chk("mid_rst_illegal", bus.illegal_op, 0);
        chk("mid_rst_running", bus.running, 0);
        rst_n = 1'b1;
        tick();

        // counter wrap on the narrow-counter instance
        bus_w.start = 1;
        tick();
        bus_w.start = 0;
        for (int i = 1; i <= 16; i++) begin
            bus_w.ir_load = 1; bus_w.dr_in = 8'h10;
            tick();
            bus_w.ir_load = 0;
            chk("wrap_count", bus_w.instr_count, i % 16);
            bus_w.IRIn = 6'd1;
            tick();
            bus_w.IRIn = 0;
        end
        chk("wrap_IROut", bus_w.IROut, 1);

        tick();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
